// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared FSM states and word geometry for the instruction-memory loader
package imem_loader_pkg;
  localparam int WORD_BYTES = 4;
  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;
endpackage

// File: rtl/imem_loader_be_word_packer.sv
// be_word_packer: big-endian byte-to-word shifter; word_valid marks the 4th byte of a word
module be_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        take,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        word_valid
);
  logic [23:0] sh;
  logic [1:0]  cnt;
  // the 4th byte is appended combinationally, so only the first three need storage
  assign word       = {sh, data};
  assign word_valid = take && cnt == 2'(WORD_BYTES - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh  <= '0;
      cnt <= '0;
    end else if (clr) begin
      sh  <= '0;
      cnt <= '0;
    end else if (take) begin
      sh  <= {sh[15:0], data};
      cnt <= cnt + 2'd1;
    end
  end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: streams bytes into the instruction store as big-endian 32b word writes
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W   = 64,
  parameter int IM_BYTES = 64,
  parameter int CNT_W    = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_words,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);
  state_t            state, nxt;
  logic [ADDR_W-1:0] cur_addr;
  logic [CNT_W-1:0]  words_left;
  logic [31:0]       word;
  logic              word_valid, take, bad, accept, err_nxt;
  logic [ADDR_W:0]   end_addr;

  assign take = s_valid && s_ready;
  // one extra bit so a base near the top of the address space cannot wrap into range
  assign end_addr = {1'b0, base_addr} + (ADDR_W+1)'({num_words, 2'b00});
  assign bad = base_addr[1:0] != 2'b00 || end_addr > (ADDR_W+1)'(IM_BYTES);

  be_word_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (accept),
    .take       (take),
    .data       (s_data),
    .word       (word),
    .word_valid (word_valid)
  );

  always_comb begin
    nxt     = state;
    err_nxt = 1'b0;
    accept  = 1'b0;
    case (state)
      IDLE: if (start) begin
        err_nxt = bad;
        accept  = !bad && num_words != '0;
        nxt     = bad ? IDLE : (num_words == '0 ? DONE : COLLECT);
      end
      COLLECT: nxt = word_valid ? WRITE : COLLECT;
      WRITE:   nxt = words_left == CNT_W'(1) ? DONE : COLLECT;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ready    <= 1'b0;
      im_we      <= 1'b0;
      im_addr    <= '0;
      im_wdata   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      cur_addr   <= '0;
      words_left <= '0;
    end else begin
      s_ready <= nxt == COLLECT;
      im_we   <= nxt == WRITE;
      busy    <= nxt == COLLECT || nxt == WRITE;
      done    <= nxt == DONE;
      err     <= err_nxt;
      if (accept) begin
        cur_addr   <= base_addr;
        words_left <= num_words;
      end
      if (word_valid) begin
        im_addr  <= cur_addr;
        im_wdata <= word;
      end
      if (state == WRITE) begin
        cur_addr   <= cur_addr + ADDR_W'(WORD_BYTES);
        words_left <= words_left - CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized byte loads checked against a queue-based model of expected word writes
module tb_imem_loader;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [63:0] base_addr = '0;
  logic [4:0]  num_words = '0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = '0;
  logic        s_ready, im_we, busy, done, err;
  logic [63:0] im_addr;
  logic [31:0] im_wdata;

  int checks = 0, errors = 0;
  int we_cnt = 0, done_cnt = 0, err_cnt = 0, ready_cnt = 0;
  logic [63:0] exp_addr[$];
  logic [31:0] exp_data[$];

  imem_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .num_words(num_words),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .im_we(im_we), .im_addr(im_addr),
    .im_wdata(im_wdata), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (s_ready) ready_cnt++;
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (err || done) chk("err_done_excl", {63'b0, err & done}, 64'd0);
    if (im_we) begin
      we_cnt++;
      if (exp_addr.size() == 0) chk("unexpected_we", 64'd1, 64'd0);
      else begin
        chk("we_addr", im_addr, exp_addr.pop_front());
        chk("we_data", {32'b0, im_wdata}, {32'b0, exp_data.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_load(input logic [63:0] b, input int n, input logic [7:0] q[$]);
    for (int i = 0; i < n; i++) begin
      exp_addr.push_back(b + 64'(4 * i));
      exp_data.push_back({q[4*i], q[4*i+1], q[4*i+2], q[4*i+3]});
    end
  endtask

  task automatic do_start(input logic [63:0] b, input logic [4:0] n);
    base_addr = b;
    num_words = n;
    start = 1'b1;
    tick();
    start = 1'b0;
    base_addr = $urandom;
    num_words = $urandom;
  endtask

  task automatic send(input logic [7:0] b, input bit gaps);
    logic r;
    if (gaps) repeat ($urandom_range(0, 3)) begin
      s_valid = 1'b0;
      s_data = $urandom;
      tick();
    end
    s_valid = 1'b1;
    s_data = b;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      r = s_ready;
      @(posedge clk);
      #1;
      if (r) begin
        s_valid = 1'b0;
        s_data = $urandom;
        return;
      end
    end
    s_valid = 1'b0;
    chk("ready_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_done(input int prev);
    for (int i = 0; i < 200; i++) begin
      if (done_cnt != prev) return;
      tick();
    end
    chk("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_load(input logic [63:0] b, input int n, input bit gaps);
    logic [7:0] q[$];
    int d0, w0;
    for (int i = 0; i < 4 * n; i++) q.push_back(8'($urandom));
    model_load(b, n, q);
    d0 = done_cnt;
    w0 = we_cnt;
    do_start(b, 5'(n));
    foreach (q[i]) send(q[i], gaps);
    wait_done(d0);
    chk("we_count", 64'(we_cnt - w0), 64'(n));
    chk("pending", 64'(exp_addr.size()), 64'd0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_ready"}, {63'b0, s_ready}, 64'd0);
    chk({tag, "_we"}, {63'b0, im_we}, 64'd0);
    chk({tag, "_addr"}, im_addr, 64'd0);
    chk({tag, "_wdata"}, {32'b0, im_wdata}, 64'd0);
    chk({tag, "_busy"}, {63'b0, busy}, 64'd0);
    chk({tag, "_done"}, {63'b0, done}, 64'd0);
    chk({tag, "_err"}, {63'b0, err}, 64'd0);
  endtask

  task automatic bad_start(input string tag, input logic [63:0] b, input logic [4:0] n);
    int e0, r0, w0, d0;
    e0 = err_cnt; r0 = ready_cnt; w0 = we_cnt; d0 = done_cnt;
    do_start(b, n);
    repeat (3) tick();
    chk({tag, "_err"}, 64'(err_cnt - e0), 64'd1);
    chk({tag, "_ready"}, 64'(ready_cnt - r0), 64'd0);
    chk({tag, "_we"}, 64'(we_cnt - w0), 64'd0);
    chk({tag, "_done"}, 64'(done_cnt - d0), 64'd0);
  endtask

  initial begin
    logic [7:0] q[$];
    int d0, w0, e0, r0;
    @(negedge clk);
    chk_outputs_zero("reset");
    tick();
    rst_n = 1'b1;
    tick();

    // directed single word with latency checks
    q = '{8'hF8, 8'h40, 8'h01, 8'h42};
    model_load(64'd0, 1, q);
    d0 = done_cnt; w0 = we_cnt;
    do_start(64'd0, 5'd1);
    foreach (q[i]) send(q[i], 1'b0);
    @(negedge clk);
    chk("t1_we", {63'b0, im_we}, 64'd1);
    chk("t1_busy_write", {63'b0, busy}, 64'd1);
    @(negedge clk);
    chk("t1_done", {63'b0, done}, 64'd1);
    chk("t1_busy_done", {63'b0, busy}, 64'd0);
    tick();
    chk("t1_we_count", 64'(we_cnt - w0), 64'd1);
    chk("t1_done_count", 64'(done_cnt - d0), 64'd1);

    run_load(64'd8, 3, 1'b1);

    bad_start("misaligned", 64'd2, 5'd1);
    bad_start("overflow", 64'd60, 5'd2);
    bad_start("wrap", 64'hFFFF_FFFF_FFFF_FFFC, 5'd1);
    bad_start("too_many", 64'd0, 5'd17);
    run_load(64'd60, 1, 1'b0);
    run_load(64'd0, 16, 1'b1);

    d0 = done_cnt; w0 = we_cnt; e0 = err_cnt; r0 = ready_cnt;
    do_start(64'd0, 5'd0);
    repeat (3) tick();
    chk("zero_done", 64'(done_cnt - d0), 64'd1);
    chk("zero_we", 64'(we_cnt - w0), 64'd0);
    chk("zero_ready", 64'(ready_cnt - r0), 64'd0);
    chk("zero_err", 64'(err_cnt - e0), 64'd0);

    // reset in the middle of a word: nothing may be written
    w0 = we_cnt;
    do_start(64'd0, 5'd2);
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    chk("mid_busy", {63'b0, busy}, 64'd1);
    rst_n = 1'b0;
    #2;
    chk_outputs_zero("midreset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("midreset_we", 64'(we_cnt - w0), 64'd0);
    run_load(64'd4, 2, 1'b1);

    // start while collecting must be ignored
    q.delete();
    for (int i = 0; i < 8; i++) q.push_back(8'($urandom));
    model_load(64'd16, 2, q);
    d0 = done_cnt; w0 = we_cnt; e0 = err_cnt;
    do_start(64'd16, 5'd2);
    send(q[0], 1'b0);
    send(q[1], 1'b0);
    do_start(64'd0, 5'd1);
    for (int i = 2; i < 8; i++) send(q[i], 1'b1);
    wait_done(d0);
    chk("restart_err", 64'(err_cnt - e0), 64'd0);
    chk("restart_we", 64'(we_cnt - w0), 64'd2);

    for (int k = 0; k < 12; k++) begin
      logic [63:0] b;
      b = 64'(4 * $urandom_range(0, 15));
      if (k % 4 == 3) bad_start("rand_bad", b + 64'($urandom_range(1, 3)), 5'd1);
      run_load(b, $urandom_range(1, (64 - int'(b)) / 4), 1'($urandom));
    end

    tick();
    chk("pending_end", 64'(exp_addr.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
